alu_stack_driver: RTL and testbench

- Operand-stack sequencer that drives the core's combinational ALU: the other end of the ALU interface.
- Accepts commands over valid/ready, holds operands on a small internal stack, and presents registered a/b/ic/opcode to the ALU.
- Captures out/oc/oo back onto the stack and into flags; sits between decode and the ALU.

---
 rtl/alu_stack_driver.sv | 152 +++++++++++++++
 tb/tb_alu_stack_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stack_driver.sv
// alu_stack_driver: operand-stack sequencer feeding a combinational ALU.
// Commands (PUSH/OP/POP/DUP) arrive over valid/ready. Operands live on a
// small internal stack. OP registers NOS/TOS/opcode onto the ALU inputs for
// one EXEC cycle and then writes the result back in place of NOS.
// Optional macro ALU_DRIVER_IC_EN: alu_ic carries flag_c into the next OP
// for multi-word carry chaining. When the macro is undefined, alu_ic is tied to 0.

// Opcode encoding follows alu_opcodes.sv. This fallback applies only when that file is absent.
`ifndef OP_ADD
`define OP_ADD 4'h0
`endif

module alu_stack_driver #(
  parameter int WIDTH_MAG = 5,
  parameter int DEPTH_MAG = 3,
  localparam int WIDTH = 1 << WIDTH_MAG,
  localparam int DEPTH = 1 << DEPTH_MAG
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_kind,
  input  logic [3:0]           cmd_opcode,
  input  logic [WIDTH-1:0]     cmd_imm,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_ic,
  output logic [3:0]           alu_opcode,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_oc,
  input  logic                 alu_oo,
  output logic [WIDTH-1:0]     tos,
  output logic [DEPTH_MAG:0]   depth,
  output logic                 flag_c,
  output logic                 flag_o,
  output logic                 fault
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE and outside reset. A command must be held until it transfers.

  localparam logic [1:0] KIND_PUSH = 2'd0;
  localparam logic [1:0] KIND_OP   = 2'd1;
  localparam logic [1:0] KIND_POP  = 2'd2;
  localparam logic [1:0] KIND_DUP  = 2'd3;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
  state_t state;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_MAG-1:0] push_idx;
  logic [DEPTH_MAG-1:0] top_idx;
  logic [DEPTH_MAG-1:0] nos_idx;
  logic                 empty;
  logic                 full;
  logic                 has_two;
  logic                 accept;
  logic [WIDTH-1:0]     top_raw;

  // When depth==DEPTH, push_idx wraps to 0. It is never used for a write then.
  assign push_idx  = depth[DEPTH_MAG-1:0];
  assign top_idx   = push_idx - DEPTH_MAG'(1);
  assign nos_idx   = push_idx - DEPTH_MAG'(2);
  assign empty     = (depth == '0);
  assign full      = (depth == (DEPTH_MAG+1)'(DEPTH));
  assign has_two   = (depth >= (DEPTH_MAG+1)'(2));
  assign top_raw   = mem[top_idx];
  assign tos       = empty ? '0 : top_raw;
  assign cmd_ready = reset_n && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifndef ALU_DRIVER_IC_EN
  assign alu_ic = 1'b0;
`endif

  // Control FSM: depth, flags, fault pulse and registered ALU operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      depth      <= '0;
      flag_c     <= 1'b0;
      flag_o     <= 1'b0;
      fault      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
`ifdef ALU_DRIVER_IC_EN
      alu_ic     <= 1'b0;
`endif
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_kind)
              KIND_PUSH: begin
                if (!full) depth <= depth + 1'b1;
                else       fault <= 1'b1;
              end
              KIND_POP: begin
                if (!empty) depth <= depth - 1'b1;
                else        fault <= 1'b1;
              end
              KIND_DUP: begin
                if (!empty && !full) depth <= depth + 1'b1;
                else                 fault <= 1'b1;
              end
              default: begin // KIND_OP
                if (has_two) begin
                  alu_a      <= mem[nos_idx];
                  alu_b      <= top_raw;
                  alu_opcode <= cmd_opcode;
`ifdef ALU_DRIVER_IC_EN
                  alu_ic     <= flag_c;
`endif
                  state      <= EXEC;
                end else begin
                  fault <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin // EXEC: result replaces NOS and TOS is dropped
          depth <= depth - 1'b1;
          // The ALU drives x on oc/oo for other opcodes, so only ADD may touch the flags.
          if (alu_opcode == `OP_ADD) begin
            flag_c <= alu_oc;
            flag_o <= alu_oo;
          end
          state <= IDLE;
        end
      endcase
    end
  end

  // Stack RAM writes. The RAM is not cleared, and reset suppresses any pending writeback.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == EXEC) begin
        mem[nos_idx] <= alu_out;
      end else if (accept) begin
        if (cmd_kind == KIND_PUSH && !full)
          mem[push_idx] <= cmd_imm;
        else if (cmd_kind == KIND_DUP && !empty && !full)
          mem[push_idx] <= top_raw;
      end
    end
  end

endmodule

// File: tb/tb_alu_stack_driver.sv
// Directed testbench for alu_stack_driver, with a behavioural ALU model on the far side.

`ifndef OP_ADD
`define OP_ADD 4'h0
`endif
`ifndef OP_AND
`define OP_AND 4'h2
`endif
`ifndef OP_LSR
`define OP_LSR 4'h7
`endif
`ifndef OP_CSL
`define OP_CSL 4'h8
`endif

module tb_alu_stack_driver;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_OP   = 2'd1;
  localparam logic [1:0] K_POP  = 2'd2;
  localparam logic [1:0] K_DUP  = 2'd3;

`ifdef ALU_DRIVER_IC_EN
  localparam logic IC_ON = 1'b1;
`else
  localparam logic IC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = 2'd0;
  logic [3:0]  cmd_opcode = 4'd0;
  logic [31:0] cmd_imm = 32'd0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_ic, alu_oc, alu_oo;
  logic [3:0]  alu_opcode;
  logic [31:0] tos;
  logic [3:0]  depth;
  logic        flag_c, flag_o, fault;

  int checks = 0;
  int passes = 0;
  time accept_time;

  alu_stack_driver #(.WIDTH_MAG(5), .DEPTH_MAG(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo),
    .tos(tos), .depth(depth), .flag_c(flag_c), .flag_o(flag_o), .fault(fault)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural ALU: a = NOS, b = TOS (shift amount); carry/overflow are x except for ADD.
  logic [32:0] sum;
  always_comb begin
    sum     = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ic};
    alu_out = alu_a;
    alu_oc  = 1'bx;
    alu_oo  = 1'bx;
    case (alu_opcode)
      `OP_ADD: begin
        alu_out = sum[31:0];
        alu_oc  = sum[32];
        alu_oo  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      `OP_AND: alu_out = alu_a & alu_b;
      `OP_LSR: alu_out = alu_a >> alu_b[4:0];
      `OP_CSL: alu_out = (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}));
      default: alu_out = alu_a;
    endcase
  end

  // Driver: offer one command, wait (bounded) for ready, return #1 after the transfer edge.
  task automatic issue(input logic [1:0] kind, input logic [3:0] op, input logic [31:0] imm);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checks++;
      $display("FAIL issue_timeout cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_kind   = kind;
    cmd_opcode = op;
    cmd_imm    = imm;
    @(posedge clk);
    accept_time = $time;
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", cmd_ready); else passes++;
    checks++; if (depth !== 4'd0) $display("FAIL rst_depth got=%0d exp=0", depth); else passes++;
    checks++; if (tos !== 32'd0) $display("FAIL rst_tos got=%h exp=0", tos); else passes++;
    checks++; if ({flag_c, flag_o, fault} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {flag_c, flag_o, fault}); else passes++;
    checks++; if ({alu_a, alu_b, alu_ic, alu_opcode} !== 69'd0) $display("FAIL rst_alu got=%h/%h/%b/%h exp=0", alu_a, alu_b, alu_ic, alu_opcode); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", cmd_ready); else passes++;
  endtask

  task automatic test_add_basic();
    issue(K_PUSH, 4'd0, 32'd5);
    issue(K_PUSH, 4'd0, 32'd7);
    issue(K_OP, `OP_ADD, 32'd0);
    @(negedge clk); // EXEC cycle
    checks++; if (cmd_ready !== 1'b0) $display("FAIL add_exec_ready got=%b exp=0", cmd_ready); else passes++;
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL add_operands got=%0d,%0d exp=5,7", alu_a, alu_b); else passes++;
    checks++; if (alu_opcode !== `OP_ADD || alu_ic !== 1'b0) $display("FAIL add_opcode got=%h ic=%b exp=%h ic=0", alu_opcode, alu_ic, `OP_ADD); else passes++;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL add_ready_back got=%b exp=1", cmd_ready); else passes++;
    checks++; if (tos !== 32'd12 || depth !== 4'd1) $display("FAIL add_result got=%0d d=%0d exp=12 d=1", tos, depth); else passes++;
    checks++; if (flag_c !== 1'b0 || flag_o !== 1'b0) $display("FAIL add_flags got=%b%b exp=00", flag_c, flag_o); else passes++;
    issue(K_POP, 4'd0, 32'd0);
  endtask

  task automatic test_flags();
    logic [31:0] exp_t;
    issue(K_PUSH, 4'd0, 32'hFFFF_FFFF);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_ADD, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (tos !== 32'd0 || flag_c !== 1'b1 || flag_o !== 1'b0) $display("FAIL carry_add got=%h c=%b o=%b exp=0 c=1 o=0", tos, flag_c, flag_o); else passes++;
    issue(K_POP, 4'd0, 32'd0);
    issue(K_PUSH, 4'd0, 32'h7FFF_FFFF);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_ADD, 32'd0);
    repeat (2) @(negedge clk);
    exp_t = IC_ON ? 32'h8000_0001 : 32'h8000_0000;
    checks++; if (tos !== exp_t || flag_c !== 1'b0 || flag_o !== 1'b1) $display("FAIL ovf_add got=%h c=%b o=%b exp=%h c=0 o=1", tos, flag_c, flag_o, exp_t); else passes++;
    issue(K_POP, 4'd0, 32'd0);
    issue(K_PUSH, 4'd0, 32'd3);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_AND, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (tos !== 32'd1 || flag_c !== 1'b0 || flag_o !== 1'b1) $display("FAIL and_keeps_flags got=%h c=%b o=%b exp=1 c=0 o=1", tos, flag_c, flag_o); else passes++;
  endtask

  task automatic test_faults();
    apply_reset();
    issue(K_OP, `OP_ADD, 32'd0);
    checks++; if (fault !== 1'b1 || depth !== 4'd0) $display("FAIL op_empty got fault=%b d=%0d exp fault=1 d=0", fault, depth); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL op_empty_idle got=%b exp=1", cmd_ready); else passes++;
    issue(K_POP, 4'd0, 32'd0);
    checks++; if (fault !== 1'b1 || depth !== 4'd0) $display("FAIL pop_empty got fault=%b d=%0d exp fault=1 d=0", fault, depth); else passes++;
    @(posedge clk); #1;
    checks++; if (fault !== 1'b0) $display("FAIL fault_one_cycle got=%b exp=0", fault); else passes++;
    for (int i = 0; i < 7; i++) issue(K_PUSH, 4'd0, 32'd10 + 32'(i));
    issue(K_DUP, 4'd0, 32'd0);
    checks++; if (fault !== 1'b0 || depth !== 4'd8 || tos !== 32'd16) $display("FAIL dup_ok got fault=%b d=%0d t=%0d exp 0 8 16", fault, depth, tos); else passes++;
    issue(K_PUSH, 4'd0, 32'd99);
    checks++; if (fault !== 1'b1 || depth !== 4'd8 || tos !== 32'd16) $display("FAIL push_full got fault=%b d=%0d t=%0d exp 1 8 16", fault, depth, tos); else passes++;
    issue(K_DUP, 4'd0, 32'd0);
    checks++; if (fault !== 1'b1 || depth !== 4'd8) $display("FAIL dup_full got fault=%b d=%0d exp 1 8", fault, depth); else passes++;
    issue(K_POP, 4'd0, 32'd0);
    issue(K_POP, 4'd0, 32'd0);
    checks++; if (fault !== 1'b0 || depth !== 4'd6 || tos !== 32'd15) $display("FAIL pop_ok got fault=%b d=%0d t=%0d exp 0 6 15", fault, depth, tos); else passes++;
  endtask

  task automatic test_shifts();
    apply_reset();
    issue(K_PUSH, 4'd0, 32'h8000_0001);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_CSL, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (tos !== 32'h0000_0003 || depth !== 4'd1) $display("FAIL csl got=%h d=%0d exp=3 d=1", tos, depth); else passes++;
    issue(K_POP, 4'd0, 32'd0);
    issue(K_PUSH, 4'd0, 32'h80);
    issue(K_PUSH, 4'd0, 32'd4);
    issue(K_OP, `OP_LSR, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (tos !== 32'h8 || depth !== 4'd1) $display("FAIL lsr got=%h d=%0d exp=8 d=1", tos, depth); else passes++;
  endtask

  task automatic test_reset_exec();
    apply_reset();
    issue(K_PUSH, 4'd0, 32'hFFFF_FFFF);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_ADD, 32'd0);
    reset_n = 1'b0; // lands during EXEC
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (depth !== 4'd0 || tos !== 32'd0) $display("FAIL rst_exec got d=%0d t=%h exp d=0 t=0", depth, tos); else passes++;
    checks++; if (flag_c !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_exec_flags got c=%b rdy=%b exp c=0 rdy=1", flag_c, cmd_ready); else passes++;
  endtask

  task automatic test_ic();
    logic exp_ic;
    apply_reset();
    issue(K_PUSH, 4'd0, 32'hFFFF_FFFF);
    issue(K_PUSH, 4'd0, 32'd1);
    issue(K_OP, `OP_ADD, 32'd0);
    @(negedge clk);
    checks++; if (alu_ic !== 1'b0) $display("FAIL ic_first got=%b exp=0", alu_ic); else passes++;
    issue(K_PUSH, 4'd0, 32'd2);
    issue(K_PUSH, 4'd0, 32'd3);
    issue(K_OP, `OP_AND, 32'd0);
    @(negedge clk);
    exp_ic = IC_ON;
    checks++; if (alu_ic !== exp_ic || flag_c !== 1'b1) $display("FAIL ic_chain got=%b c=%b exp=%b c=1", alu_ic, flag_c, exp_ic); else passes++;
  endtask

  task automatic test_back_to_back();
    time t0;
    apply_reset();
    for (int i = 1; i <= 4; i++) issue(K_PUSH, 4'd0, 32'(i));
    issue(K_OP, `OP_ADD, 32'd0);
    t0 = accept_time;
    issue(K_OP, `OP_ADD, 32'd0);
    issue(K_OP, `OP_ADD, 32'd0);
    checks++; if (accept_time - t0 !== 40) $display("FAIL b2b_rate got=%0t exp=40", accept_time - t0); else passes++;
    @(negedge clk); @(negedge clk);
    checks++; if (tos !== 32'd10 || depth !== 4'd1) $display("FAIL b2b_result got=%0d d=%0d exp=10 d=1", tos, depth); else passes++;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_flags();
    test_faults();
    test_shifts();
    test_reset_exec();
    test_ic();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
